mem_req_arbiter: RTL

- Shares one sram-like memory port between the fetch stage (read-only instruction requester) and the memory stage (read/write data requester).
- Uses a req/addr_ok/data_ok handshake with one outstanding transaction at a time.
- Data requests have priority. A streak counter prevents instruction starvation.
- Provides an inst_cancel input so that exception flushes can drop a stale fetch response.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_req_arbiter_if.sv | 45 ++++
 rtl/mem_arb_grant.sv | 35 +++
 rtl/mem_req_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and the latched memory-command record for the memory request arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_INST = 2'd1, OWN_DATA = 2'd2} owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester and memory-side handshake bundle; slave = arbiter view, master = environment view.
interface mem_req_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_cancel;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision for the idle arbiter: data wins unless the fetch side has been
// passed over MAX_DATA_STREAK times in a row while waiting.
module mem_arb_grant #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic data_req,
  input  logic idle,
  output logic grant_inst,
  output logic grant_data
);
  localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);

  logic [3:0] streak_q, streak_d;
  logic       force_inst;

  assign force_inst = inst_req && (streak_q == MAX_S);
  assign grant_data = idle && data_req && !force_inst;
  assign grant_inst = idle && inst_req && !grant_data;

  // Streak counts only data grants that bypassed a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (grant_data)
      streak_d = !inst_req ? 4'd0 : (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
    else if (grant_inst)
      streak_d = 4'd0;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) streak_q <= 4'd0;
    else         streak_q <= streak_d;
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like port between fetch and memory stages, one transaction in flight.
module mem_req_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                resetn,
  mem_req_arbiter_if.slave    bus
);
  state_e   state_q, state_d;
  owner_e   owner_q, owner_d;
  logic     cancel_q, cancel_d;
  mem_cmd_t cmd_q, cmd_d;
  logic     grant_inst, grant_data, resp_done, cancel_hit;

  mem_arb_grant #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_grant (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (bus.inst_req),
    .data_req   (bus.data_req),
    .idle       (state_q == ST_IDLE),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  // Responses only count in RESP; stray mem_data_ok in IDLE/REQ is dropped.
  assign resp_done  = (state_q == ST_RESP) && bus.mem_data_ok;
  assign cancel_hit = bus.inst_cancel &&
                      (((state_q != ST_IDLE) && (owner_q == OWN_INST)) || grant_inst);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_inst || grant_data) state_d = ST_REQ;
      ST_REQ:  if (bus.mem_addr_ok)          state_d = ST_RESP;
      ST_RESP: if (bus.mem_data_ok)          state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    cancel_d = cancel_q;
    cmd_d    = cmd_q;
    if (grant_data) begin
      owner_d = OWN_DATA;
      cmd_d   = '{wr: bus.data_wr, size: bus.data_size, wstrb: bus.data_wstrb,
                  addr: bus.data_addr, wdata: bus.data_wdata};
    end else if (grant_inst) begin
      owner_d = OWN_INST;
      cmd_d   = '{wr: 1'b0, size: SZ_WORD, wstrb: 4'h0, addr: bus.inst_addr, wdata: 32'h0};
    end else if (resp_done) begin
      owner_d = OWN_NONE;
    end
    if (resp_done)       cancel_d = 1'b0;
    else if (cancel_hit) cancel_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      owner_q  <= OWN_NONE;
      cancel_q <= 1'b0;
      cmd_q    <= '0;
    end else begin
      owner_q  <= owner_d;
      cancel_q <= cancel_d;
      cmd_q    <= cmd_d;
    end

  // A cancel arriving in the response cycle itself still suppresses the pulse.
  always_comb begin
    bus.inst_addr_ok = grant_inst;
    bus.data_addr_ok = grant_data;
    bus.mem_req      = (state_q == ST_REQ);
    bus.mem_wr       = cmd_q.wr;
    bus.mem_size     = cmd_q.size;
    bus.mem_wstrb    = cmd_q.wstrb;
    bus.mem_addr     = cmd_q.addr;
    bus.mem_wdata    = cmd_q.wdata;
    bus.inst_data_ok = resp_done && (owner_q == OWN_INST) && !(cancel_q || bus.inst_cancel);
    bus.data_data_ok = resp_done && (owner_q == OWN_DATA);
    bus.inst_rdata   = ((state_q == ST_RESP) && (owner_q == OWN_INST)) ? bus.mem_rdata : 32'h0;
    bus.data_rdata   = ((state_q == ST_RESP) && (owner_q == OWN_DATA)) ? bus.mem_rdata : 32'h0;
  end
endmodule
